// File: rtl/msg_scheduler.sv
// Round-robin scheduler that launches latched message requests onto a single messenger,
// waiting for done or timeout and enforcing an idle gap between messages.
module msg_scheduler #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_msg,
  output logic [3:0]           msg_index,
  output logic                 msg_start,
  input  logic                 msg_done,
  output logic [N_REQ-1:0]     pending,
  output logic [N_REQ-1:0]     served,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 overflow
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [PTR_W-1:0] ptr, ptr_next, grant_id, grant_id_next;
  logic [PTR_W-1:0] arb_idx, cand;
  logic             arb_found;
  logic [3:0]       msg_store [N_REQ];
  logic [3:0]       msg_index_next;
  logic             msg_start_next, timeout_next, overflow_next;
  logic [N_REQ-1:0] pending_next, served_next, grant_clr, store_en;

  // Search starts just after the last granted slot so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    ptr_next       = ptr;
    grant_id_next  = grant_id;
    msg_index_next = msg_index;
    msg_start_next = 1'b0;
    served_next    = '0;
    timeout_next   = 1'b0;
    grant_clr      = '0;

    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_clr[arb_idx] = 1'b1;
          msg_index_next     = msg_store[arb_idx];
          msg_start_next     = 1'b1;
          cnt_next           = '0;
          ptr_next           = arb_idx;
          grant_id_next      = arb_idx;
          state_next         = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt + CNT_W'(1);
        if (msg_done || cnt == TO_LAST) begin
          served_next[grant_id] = 1'b1;
          timeout_next          = !msg_done;
          if (GAP_CYCLES == 0) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next   = GAP_LOAD;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase

    // A new request in the cycle its slot is granted re-arms the slot instead of overflowing.
    pending_next  = (pending & ~grant_clr) | req;
    overflow_next = |(req & pending & ~grant_clr);
    store_en      = req & (~pending | grant_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= PTR_W'(N_REQ - 1);
      grant_id    <= '0;
      msg_index   <= '0;
      msg_start   <= 1'b0;
      pending     <= '0;
      served      <= '0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ptr         <= ptr_next;
      grant_id    <= grant_id_next;
      msg_index   <= msg_index_next;
      msg_start   <= msg_start_next;
      pending     <= pending_next;
      served      <= served_next;
      timeout_err <= timeout_next;
      overflow    <= overflow_next;
    end
  end

  // NOTE: the index store has no reset; a slot is only read after its pending bit was set by a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (store_en[i]) msg_store[i] <= req_msg[4*i +: 4];
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_msg_scheduler.sv
// Directed self-checking bench for msg_scheduler (N_REQ=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20).
module tb_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_msg;
  logic [3:0]  msg_index;
  logic        msg_start;
  logic        msg_done;
  logic [3:0]  pending;
  logic [3:0]  served;
  logic        busy;
  logic        timeout_err;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  msg_scheduler #(
    .N_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
    .msg_index(msg_index), .msg_start(msg_start), .msg_done(msg_done),
    .pending(pending), .served(served), .busy(busy),
    .timeout_err(timeout_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant edge: start pulse with the expected index.
  task automatic launch_check(input string tag, input logic [3:0] exp_idx);
    tick();
    check({tag, "_start"}, 32'(msg_start), 1);
    check({tag, "_index"}, 32'(msg_index), 32'(exp_idx));
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Start drops, done arrives, two gap cycles, then back in IDLE for one cycle.
  task automatic finish_msg(input string tag, input logic [3:0] exp_served);
    tick();
    req = '0;
    check({tag, "_start_low"}, 32'(msg_start), 0);
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    check({tag, "_served"}, 32'(served), 32'(exp_served));
    check({tag, "_to_err"}, 32'(timeout_err), 0);
    tick();
    check({tag, "_gap_busy"}, 32'(busy), 1);
    check({tag, "_served_clr"}, 32'(served), 0);
    tick();
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_msg = '0; msg_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_outputs", 32'({msg_index, msg_start, pending, served, busy, timeout_err, overflow}), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", 32'({msg_index, msg_start, pending, served, busy, timeout_err, overflow}), 0);
    end

    // Single request on slot 1.
    req = 4'b0010; req_msg = 16'h0050;
    tick();
    req = '0;
    check("s1_pending", 32'(pending), 'h2);
    check("s1_no_start", 32'(msg_start), 0);
    launch_check("s1", 4'h5);
    check("s1_pend_clr", 32'(pending), 0);
    tick();
    check("s1_start_one", 32'(msg_start), 0);
    check("s1_index_hold", 32'(msg_index), 'h5);
    for (int i = 0; i < 4; i++) tick();
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    check("s1_served", 32'(served), 'h2);
    check("s1_gap1", 32'(busy), 1);
    tick();
    check("s1_gap2", 32'(busy), 1);
    check("s1_served_pulse", 32'(served), 0);
    tick();
    check("s1_idle", 32'(busy), 0);

    // Round-robin from a fresh pointer: slots 0,1,3 then slot 0 re-requests.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1011; req_msg = 16'h8021;
    tick();
    req = '0;
    check("rr_pending", 32'(pending), 'hB);
    launch_check("rr0", 4'h1);
    check("rr0_pend", 32'(pending), 'hA);
    finish_msg("rr0", 4'b0001);
    launch_check("rr1", 4'h2);
    check("rr1_pend", 32'(pending), 'h8);
    req = 4'b0001; req_msg = 16'h0009;
    finish_msg("rr1", 4'b0010);
    check("rr_re_pend", 32'(pending), 'h9);
    launch_check("rr3", 4'h8);
    finish_msg("rr3", 4'b1000);
    launch_check("rr0b", 4'h9);
    finish_msg("rr0b", 4'b0001);

    // Overflow: second request on slot 2 while it is still pending.
    req = 4'b0010; req_msg = 16'h0040;
    tick();
    req = '0;
    launch_check("ov_s1", 4'h4);
    req = 4'b0100; req_msg = 16'h0300;
    tick();
    check("ov_first_ok", 32'(overflow), 0);
    check("ov_pend", 32'(pending), 'h4);
    req_msg = 16'h0700;
    tick();
    req = '0;
    check("ov_pulse", 32'(overflow), 1);
    tick();
    check("ov_pulse_end", 32'(overflow), 0);
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    check("ov_s1_served", 32'(served), 'h2);
    tick(); tick();
    check("ov_idle", 32'(busy), 0);
    launch_check("ov_s2", 4'h3);
    finish_msg("ov_s2", 4'b0100);

    // Timeout with done withheld.
    req = 4'b1000; req_msg = 16'hA000;
    tick();
    req = '0;
    launch_check("to", 4'hA);
    for (int i = 0; i < 19; i++) tick();
    check("to_early", 32'(timeout_err), 0);
    tick();
    check("to_err", 32'(timeout_err), 1);
    check("to_served", 32'(served), 'h8);
    check("to_gap", 32'(busy), 1);
    tick();
    check("to_err_pulse", 32'(timeout_err), 0);
    tick();
    check("to_idle", 32'(busy), 0);

    // Done on the timeout cycle wins.
    req = 4'b0001; req_msg = 16'h000B;
    tick();
    req = '0;
    launch_check("dt", 4'hB);
    for (int i = 0; i < 19; i++) tick();
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    check("dt_no_err", 32'(timeout_err), 0);
    check("dt_served", 32'(served), 'h1);
    tick(); tick();
    check("dt_idle", 32'(busy), 0);

    // Reset in WAIT drops pending work and ignores a late done.
    req = 4'b0010; req_msg = 16'h0060;
    tick();
    req = '0;
    launch_check("rw", 4'h6);
    req = 4'b0100; req_msg = 16'h0200;
    tick();
    req = '0;
    check("rw_pend", 32'(pending), 'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_pend_clr", 32'(pending), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_start", 32'(msg_start), 0);
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    check("rw_no_served", 32'(served), 0);
    tick();
    check("rw_quiet", 32'({msg_start, served, busy, timeout_err}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
